// File: rtl/memoria_datos.sv
// memoria_datos: word-organised data RAM with byte addressing.
// Ports: clk, rst (async, active-high), escritura_habilitada,
//   lectura_habilitada, direccion, dato_escritura, dato_lectura.
// Optional macro: MEMORIA_DATOS_RANGE_CHECK_EN (drop/zero out-of-range).
module memoria_datos #(
  parameter int Ancho_Dato      = 32,
  parameter int Ancho_Direccion = 32,
  parameter int Tamanio_Mem     = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       escritura_habilitada,
  input  logic                       lectura_habilitada,
  input  logic [Ancho_Direccion-1:0] direccion,
  input  logic [Ancho_Dato-1:0]      dato_escritura,
  output logic [Ancho_Dato-1:0]      dato_lectura
);

  localparam int IW = $clog2(Tamanio_Mem);

  logic [Ancho_Dato-1:0]      mem [Tamanio_Mem];
  logic [Ancho_Direccion-1:0] palabra;
  logic [IW-1:0]              indice;
  logic                       acceso_valido;
  logic                       unused_bits;

  // Byte lanes do not exist: the low two address bits are dropped.
  assign palabra = direccion >> 2;
  assign indice  = palabra[IW-1:0];

`ifdef MEMORIA_DATOS_RANGE_CHECK_EN
  localparam logic [Ancho_Direccion-1:0] TAM =
    Ancho_Direccion'(Tamanio_Mem);

  assign acceso_valido = (palabra < TAM);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && (escritura_habilitada || lectura_habilitada)
        && !acceso_valido)
      $warning("memoria_datos: out-of-range access 0x%0h",
               direccion);
  end
`endif
`else
  // Upper index bits are truncated, so addresses alias.
  assign acceso_valido = 1'b1;
`endif

  assign unused_bits = ^{direccion[1:0], palabra};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Tamanio_Mem; i++)
        mem[i] <= '0;
    end else if (escritura_habilitada && acceso_valido) begin
      mem[indice] <= dato_escritura;
    end
  end

  always_comb begin
    dato_lectura = '0;
    if (lectura_habilitada && acceso_valido)
      dato_lectura = mem[indice];
  end

endmodule

// File: tb/tb_memoria_datos.sv
// tb_memoria_datos: self-checking bench for memoria_datos.
// Random and directed accesses against an array reference model.
module tb_memoria_datos;

  logic        clk;
  logic        rst;
  logic        we;
  logic        re;
  logic [31:0] dir;
  logic [31:0] dw;
  logic [31:0] dr;

  int checks;
  int fails;

  logic [31:0] modelo [256];

  memoria_datos dut (
    .clk                  (clk),
    .rst                  (rst),
    .escritura_habilitada (we),
    .lectura_habilitada   (re),
    .direccion            (dir),
    .dato_escritura       (dw),
    .dato_lectura         (dr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] esperado(input logic [31:0] a,
                                           input logic r);
    logic [31:0] w;
    w = a / 4;
    if (!r) return 32'h0;
`ifdef MEMORIA_DATOS_RANGE_CHECK_EN
    if (w >= 256) return 32'h0;
`endif
    return modelo[w % 256];
  endfunction

  task automatic modelo_escribe(input logic [31:0] a,
                                input logic [31:0] d);
    logic [31:0] w;
    w = a / 4;
`ifdef MEMORIA_DATOS_RANGE_CHECK_EN
    if (w >= 256) return;
`endif
    modelo[w % 256] = d;
  endtask

  task automatic modelo_borra();
    for (int i = 0; i < 256; i++) modelo[i] = 32'h0;
  endtask

  task automatic escribe(input logic [31:0] a,
                         input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; dir = a; dw = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    modelo_escribe(a, d);
  endtask

  task automatic test_reset();
    logic [31:0] lista [3];
    lista[0] = 32'h0; lista[1] = 32'h4; lista[2] = 32'h3FC;
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dir = lista[i];
      #1;
      checks++;
      if (dr !== 32'h0) begin
        fails++;
        $display("FAIL reset_init[%0h] got %h want %h",
                 lista[i], dr, 32'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    escribe(32'h3FC, 32'h0BADF00D);
    escribe(32'h4, 32'h13572468);
    re = 1'b1; dir = 32'h3FC;
    #1;
    checks++;
    if (dr !== 32'h0BADF00D) begin
      fails++;
      $display("FAIL reset_prewrite got %h want %h",
               dr, 32'h0BADF00D);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    modelo_borra();
    for (int i = 0; i < 3; i++) begin
      dir = lista[i];
      #0.5;
      checks++;
      if (dr !== 32'h0) begin
        fails++;
        $display("FAIL reset_async[%0h] got %h want %h",
                 lista[i], dr, 32'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] ad [4];
    logic [31:0] da [4];
    ad[0] = 32'h0;   da[0] = 32'hDEADBEEF;
    ad[1] = 32'h4;   da[1] = 32'hCAFEBABE;
    ad[2] = 32'h10;  da[2] = 32'h12345678;
    ad[3] = 32'h3FC; da[3] = 32'hABCDEF01;
    re = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we = 1'b1; dir = ad[i]; dw = $urandom;
      @(negedge clk);
      dw = $urandom;
      @(negedge clk);
      dw = da[i];
      @(posedge clk);
      #1 we = 1'b0;
      modelo_escribe(ad[i], da[i]);
    end
    re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dir = ad[i];
      #2;
      checks++;
      if (dr !== da[i]) begin
        fails++;
        $display("FAIL basic_read[%0h] got %h want %h",
                 ad[i], dr, da[i]);
      end
    end
  endtask

  task automatic test_read_disable();
    re = 1'b0; dir = 32'h0;
    #1;
    checks++;
    if (dr !== 32'h0) begin
      fails++;
      $display("FAIL read_disable got %h want %h", dr, 32'h0);
    end
    re = 1'b1;
    #1;
    checks++;
    if (dr !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL read_reenable got %h want %h",
               dr, 32'hDEADBEEF);
    end
  endtask

  task automatic test_same_cycle();
    escribe(32'h8, 32'h11111111);
    @(negedge clk);
    we = 1'b1; re = 1'b1; dir = 32'h8; dw = 32'h22222222;
    #1;
    checks++;
    if (dr !== 32'h11111111) begin
      fails++;
      $display("FAIL same_cycle_before got %h want %h",
               dr, 32'h11111111);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    modelo_escribe(32'h8, 32'h22222222);
    checks++;
    if (dr !== 32'h22222222) begin
      fails++;
      $display("FAIL same_cycle_after got %h want %h",
               dr, 32'h22222222);
    end
  endtask

  task automatic test_unaligned_reset_abort();
    escribe(32'h13, 32'h55AA55AA);
    re = 1'b1; dir = 32'h10;
    #1;
    checks++;
    if (dr !== 32'h55AA55AA) begin
      fails++;
      $display("FAIL unaligned_read got %h want %h",
               dr, 32'h55AA55AA);
    end
    dir = 32'h12;
    #1;
    checks++;
    if (dr !== 32'h55AA55AA) begin
      fails++;
      $display("FAIL unaligned_read2 got %h want %h",
               dr, 32'h55AA55AA);
    end
    @(negedge clk);
    we = 1'b1; dir = 32'h20; dw = 32'h99999999;
    #2 rst = 1'b1;
    modelo_borra();
    @(posedge clk);
    #1;
    checks++;
    if (dr !== 32'h0) begin
      fails++;
      $display("FAIL reset_abort got %h want %h", dr, 32'h0);
    end
    @(negedge clk);
    we = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;
    dir = 32'h10;
    #1;
    checks++;
    if (dr !== 32'h0) begin
      fails++;
      $display("FAIL reset_cleared got %h want %h", dr, 32'h0);
    end
  endtask

  task automatic test_out_of_range();
    escribe(32'h0, 32'hA5A5A5A5);
    escribe(32'h400, 32'h77777777);
    re = 1'b1; dir = 32'h0;
    #1;
    checks++;
`ifdef MEMORIA_DATOS_RANGE_CHECK_EN
    if (dr !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL oor_word0 got %h want %h", dr, 32'hA5A5A5A5);
    end
    dir = 32'h400;
    #1;
    checks++;
    if (dr !== 32'h0) begin
      fails++;
      $display("FAIL oor_read got %h want %h", dr, 32'h0);
    end
`else
    if (dr !== 32'h77777777) begin
      fails++;
      $display("FAIL oor_alias got %h want %h", dr, 32'h77777777);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] exp;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        default: a = $urandom_range(0, 32'h7FF);
      endcase
      dir = a;
      we = ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 3) != 0);
      dw = $urandom;
      #1;
      exp = esperado(a, re);
      checks++;
      if (dr !== exp) begin
        fails++;
        $display("FAIL random_pre[%0d] a=%h got %h want %h",
                 i, a, dr, exp);
      end
      @(posedge clk);
      #1;
      if (we) modelo_escribe(a, dw);
      exp = esperado(a, re);
      checks++;
      if (dr !== exp) begin
        fails++;
        $display("FAIL random_post[%0d] a=%h got %h want %h",
                 i, a, dr, exp);
      end
    end
    we = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst = 1'b1; we = 1'b0; re = 1'b0;
    dir = 32'h0; dw = 32'h0;
    modelo_borra();
    test_reset();
    test_basic();
    test_read_disable();
    test_same_cycle();
    test_unaligned_reset_abort();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
